// File: rtl/fp_pkg.sv
// Shared fp32 field layout, exponent constants and enums for the float-to-int path.
package fp_pkg;

    localparam int         FP_FRAC_W  = 23;
    localparam logic [7:0] FP_BIAS    = 8'd127;
    localparam logic [7:0] FP_EXP_MAX = 8'd255;
    // Biased exponent of 2^31: only -2^31 itself is representable there.
    localparam logic [7:0] FP_EXP_I32 = FP_BIAS + 8'd31;
    // Biased exponent at which {1,frac} is already the integer value (no shift).
    localparam logic [7:0] FP_EXP_INT = FP_BIAS + 8'(FP_FRAC_W);
    localparam int         SHIFT_CNT_W = 5;

    typedef struct packed {
        logic                 sign;
        logic [7:0]           exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } fp2int_state_e;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SMALL,
        CLS_NORMAL,
        CLS_OVF,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

endpackage

// File: rtl/fp_unpack.sv
// Combinational fp32 field split and operand classification, plus the shift
// distance/direction that brings {1,frac} to integer alignment.
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]            data_i,
    output logic                   sign_o,
    output logic [FP_FRAC_W-1:0]   frac_o,
    output logic [2:0]             class_o,
    output logic [SHIFT_CNT_W-1:0] shift_cnt_o,
    output logic                   shift_left_o
);

    fp32_t     op;
    fp_class_e cls;

    assign op     = fp32_t'(data_i);
    assign sign_o = op.sign;
    assign frac_o = op.frac;

    // NOTE: every signal written here gets a value before any branch, so no latch can be inferred.
    always_comb begin
        cls = CLS_NORMAL;
        if (op.exp == 8'd0) begin
            cls = CLS_ZERO;
        end else if (op.exp == FP_EXP_MAX) begin
            cls = (op.frac != '0) ? CLS_NAN : CLS_INF;
        end else if (op.exp < FP_BIAS) begin
            cls = CLS_SMALL;
        end else if (op.exp > FP_EXP_I32) begin
            cls = CLS_OVF;
        end else if ((op.exp == FP_EXP_I32) && !(op.sign && (op.frac == '0))) begin
            cls = CLS_OVF;
        end
    end

    assign class_o      = cls;
    assign shift_left_o = (op.exp > FP_EXP_INT);

    // |e - 23| never exceeds 23 for normal operands, so the low five bits suffice.
    assign shift_cnt_o = shift_left_o ? (op.exp[4:0] - FP_EXP_INT[4:0])
                                      : (FP_EXP_INT[4:0] - op.exp[4:0]);

endmodule

// File: rtl/fp2int_unit.sv
// Iterative fp32 -> int32 converter (truncate toward zero), one shift per cycle.
// Define FP2INT_SATURATE_EN to return saturated values on overflow instead of zero.
module fp2int_unit
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic        ovf,
    output logic        inv
);

    logic                   op_sign;
    logic [FP_FRAC_W-1:0]   op_frac;
    logic [2:0]             op_class_w;
    fp_class_e              op_class;
    logic [SHIFT_CNT_W-1:0] op_cnt;
    logic                   op_left;
    logic [31:0]            ovf_value;

    fp2int_state_e          state_q, state_d;
    logic [31:0]            mag_q, mag_d;
    logic [SHIFT_CNT_W-1:0] cnt_q, cnt_d;
    logic                   left_q, left_d;
    logic                   sign_q, sign_d;
    logic [31:0]            data_q, data_d;
    logic                   ovf_q, ovf_d;
    logic                   inv_q, inv_d;

    fp_unpack u_unpack (
        .data_i       (data_in),
        .sign_o       (op_sign),
        .frac_o       (op_frac),
        .class_o      (op_class_w),
        .shift_cnt_o  (op_cnt),
        .shift_left_o (op_left)
    );

    assign op_class = fp_class_e'(op_class_w);

`ifdef FP2INT_SATURATE_EN
    assign ovf_value = op_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    assign ovf_value = 32'h0000_0000;
`endif

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        sign_d  = sign_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        inv_d   = inv_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d  = op_sign;
                    data_d  = 32'h0;
                    ovf_d   = 1'b0;
                    inv_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    case (op_class)
                        CLS_NORMAL: begin
                            mag_d   = {8'h00, 1'b1, op_frac};
                            cnt_d   = op_cnt;
                            left_d  = op_left;
                            state_d = ST_SHIFT;
                        end
                        CLS_OVF, CLS_INF: begin
                            ovf_d  = 1'b1;
                            data_d = ovf_value;
                        end
                        CLS_NAN: begin
                            inv_d = 1'b1;
                        end
                        default: begin
                            data_d = 32'h0;
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    mag_d = left_q ? (mag_q << 1) : (mag_q >> 1);
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // -2^31 lands here as 0x80000000 and negates to itself.
                    data_d  = sign_q ? (~mag_q + 32'd1) : mag_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mag_q   <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            sign_q  <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            sign_q  <= sign_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            inv_q   <= inv_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign data_out  = data_q;
    assign ovf       = ovf_q;
    assign inv       = inv_q;

endmodule

// File: tb/tb_fp2int_unit.sv
// Scoreboard bench for fp2int_unit: random and directed operands against a
// numeric reference model; honours FP2INT_SATURATE_EN like the design.
module tb_fp2int_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] data_out;
    logic        ovf;
    logic        inv;

    typedef struct {
        logic [31:0] op;
        logic [31:0] data;
        logic        ovf;
        logic        inv;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    logic        hold_low = 1'b0;

    logic [31:0] dir_ops [19] = '{
        32'h40E0_0000, 32'hC088_0000, 32'h3F00_0000, 32'hCF00_0000, 32'h4F00_0000,
        32'h7FC0_0000, 32'hFF80_0000, 32'h7F80_0000, 32'h0000_0000, 32'h8000_0000,
        32'h0040_0000, 32'h4EFF_FFFF, 32'hCEFF_FFFF, 32'h3F80_0000, 32'hBF80_0000,
        32'h4B00_0000, 32'h4B7F_FFFF, 32'hCF00_0001, 32'h4F80_0000
    };

    fp2int_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .ovf       (ovf),
        .inv       (inv)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: value = 1.frac * 2^e, truncated toward zero, then range-checked.
    function automatic exp_t model(input logic [31:0] op);
        exp_t        r;
        int          ex;
        int          e;
        logic [63:0] mag;
        logic [31:0] sat;
        r.op = op; r.data = 32'h0; r.ovf = 1'b0; r.inv = 1'b0; r.lat = 1; r.acc = 0;
        ex = int'(op[30:23]);
`ifdef FP2INT_SATURATE_EN
        sat = op[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        sat = 32'h0;
`endif
        if (ex == 255) begin
            if (op[22:0] != 23'h0) r.inv = 1'b1;
            else begin r.ovf = 1'b1; r.data = sat; end
            return r;
        end
        if (ex == 0) return r;
        e = ex - 127;
        if (e < 0) return r;
        if (e >= 32) begin r.ovf = 1'b1; r.data = sat; return r; end
        mag = {40'h0, 1'b1, op[22:0]};
        mag = (e >= 23) ? (mag << (e - 23)) : (mag >> (23 - e));
        if ((!op[31] && mag > 64'h7FFF_FFFF) || (op[31] && mag > 64'h8000_0000)) begin
            r.ovf = 1'b1; r.data = sat; return r;
        end
        r.data = op[31] ? (32'h0 - mag[31:0]) : mag[31:0];
        r.lat  = ((e >= 23) ? (e - 23) : (23 - e)) + 2;
        return r;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 3))
            0: ;
            1: r[30:23] = 8'($urandom_range(120, 162));
            2: begin r[30:23] = 8'($urandom_range(125, 159)); r[22:16] = 7'h0; end
            default: r = dir_ops[$urandom_range(0, 18)];
        endcase
        return r;
    endfunction

    task automatic send(input logic [31:0] op);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = op;
        while (!in_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 200) begin
                check("accept_timeout", 32'(in_ready), 32'h1);
                in_valid = 1'b0;
                return;
            end
        end
        e = model(op);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || out_valid) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: first presentation checks value and latency, later cycles check stability.
    logic        seen = 1'b0;
    logic [31:0] held_data;
    logic        held_ovf, held_inv;
    exp_t        cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            check("in_ready_low_in_done", 32'(in_ready), 32'h0);
            if (!seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'h1, 32'h0);
                end else begin
                    cur = exp_q[0];
                    check($sformatf("data op=%h", cur.op), data_out, cur.data);
                    check($sformatf("ovf op=%h", cur.op), 32'(ovf), 32'(cur.ovf));
                    check($sformatf("inv op=%h", cur.op), 32'(inv), 32'(cur.inv));
                    check($sformatf("latency op=%h", cur.op), 32'(cyc + 1 - cur.acc), 32'(cur.lat));
                end
            end else begin
                check("hold_data", data_out, held_data);
                check("hold_flags", {30'h0, ovf, inv}, {30'h0, held_ovf, held_inv});
            end
            held_data = data_out;
            held_ovf  = ovf;
            held_inv  = inv;
            if (out_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                seen = 1'b0;
            end
        end
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'h1);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_data_out", data_out, 32'h0);
        check("reset_flags", {30'h0, ovf, inv}, 32'h0);

        foreach (dir_ops[i]) send(dir_ops[i]);
        drain();

        // Backpressure: result must sit unchanged for five cycles with out_ready low.
        hold_low = 1'b1;
        send(32'hC088_0000);
        waited = 0;
        while (!out_valid && waited < 100) begin @(negedge clk); waited++; end
        check("hold_result_seen", 32'(out_valid), 32'h1);
        repeat (5) @(negedge clk);
        hold_low = 1'b0;
        drain();

        // Reset in the middle of SHIFT discards the operation.
        send(32'h40E0_0000);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #2;
        check("midreset_out_valid", 32'(out_valid), 32'h0);
        check("midreset_data_out", data_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postreset_in_ready", 32'(in_ready), 32'h1);
        check("postreset_out_valid", 32'(out_valid), 32'h0);
        send(32'h40E0_0000);
        drain();

        for (int n = 0; n < 300; n++) begin
            send(rand_op());
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
